// File: rtl/sram_shift_responder.sv
// Arbitrates one-cycle read/write request pulses onto a single synchronous SRAM port; SHIFT_RESP_STATS_EN adds issued-op counters.
// Latency: request to command/ack one cycle; read data valid SRAM_RD_LATENCY cycles after its command.
// Backpressure: none; one request per type is held, and a duplicate while held is dropped and raises sticky proto_err.
module sram_shift_responder #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int SRAM_RD_LATENCY = 2,
    parameter int WR_TURNAROUND   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_ack,
    output logic [SRAM_DATA_WIDTH-1:0] rd_data,
    output logic                       rd_vld,
    input  logic                       wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
    output logic                       wr_ack,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_we,
    output logic                       sram_cs,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
    output logic                       proto_err,
    output logic [31:0]                rd_count,
    output logic [31:0]                wr_count
);

    typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR, TURN} state_t;

    localparam bit         TURN_EN   = (WR_TURNAROUND > 0);
    localparam logic [1:0] TURN_LOAD = 2'((WR_TURNAROUND > 0) ? (WR_TURNAROUND - 1) : 0);

    state_t                       state, state_nxt;
    logic [1:0]                   turn_cnt, turn_cnt_nxt;
    logic                         last_rd;
    logic                         rd_pend, wr_pend;
    logic [SRAM_ADDR_WIDTH-1:0]   rd_addr_q, wr_addr_q;
    logic [SRAM_DATA_WIDTH-1:0]   wr_data_q;
    logic                         issue_rd, issue_wr;
    logic                         rd_accept, wr_accept;
    logic [SRAM_RD_LATENCY-1:0]   vld_sr;
    logic [SRAM_RD_LATENCY:0]     vld_shift;

    // A held request may be replaced on the same edge it is issued.
    assign rd_accept = !rd_pend || issue_rd;
    assign wr_accept = !wr_pend || issue_wr;
    assign vld_shift = {vld_sr, issue_rd};

    always_comb begin
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        issue_rd     = 1'b0;
        issue_wr     = 1'b0;
        case (state)
            TURN: begin
                if (turn_cnt == 2'd0) begin
                    state_nxt = ISSUE_WR;
                    issue_wr  = 1'b1;
                end else begin
                    turn_cnt_nxt = turn_cnt - 2'd1;
                end
            end
            default: begin
                // Round-robin when both are held: prefer the type not issued last.
                if (rd_pend && (!wr_pend || !last_rd)) begin
                    state_nxt = ISSUE_RD;
                    issue_rd  = 1'b1;
                end else if (wr_pend) begin
                    if (last_rd && TURN_EN) begin
                        state_nxt    = TURN;
                        turn_cnt_nxt = TURN_LOAD;
                    end else begin
                        state_nxt = ISSUE_WR;
                        issue_wr  = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            turn_cnt   <= 2'd0;
            last_rd    <= 1'b0;
            rd_pend    <= 1'b0;
            wr_pend    <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            proto_err  <= 1'b0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_ack     <= 1'b0;
            wr_ack     <= 1'b0;
            vld_sr     <= '0;
            rd_vld     <= 1'b0;
            rd_data    <= '0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_cnt_nxt;
            if (issue_rd) begin
                last_rd <= 1'b1;
            end else if (issue_wr) begin
                last_rd <= 1'b0;
            end

            if (rd_req && rd_accept) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= rd_addr;
            end else if (issue_rd) begin
                rd_pend <= 1'b0;
            end

            if (wr_req && wr_accept) begin
                wr_pend   <= 1'b1;
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end else if (issue_wr) begin
                wr_pend <= 1'b0;
            end

            proto_err <= proto_err | (rd_req && !rd_accept) | (wr_req && !wr_accept);

            sram_cs <= issue_rd | issue_wr;
            sram_we <= issue_wr;
            rd_ack  <= issue_rd;
            wr_ack  <= issue_wr;
            if (issue_rd) begin
                sram_addr <= rd_addr_q;
            end else if (issue_wr) begin
                sram_addr  <= wr_addr_q;
                sram_wdata <= wr_data_q;
            end

            vld_sr <= vld_shift[SRAM_RD_LATENCY-1:0];
            rd_vld <= vld_sr[SRAM_RD_LATENCY-1];
            if (vld_sr[SRAM_RD_LATENCY-1]) begin
                rd_data <= sram_rdata;
            end
        end
    end

`ifdef SHIFT_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else begin
            if (issue_rd) begin
                rd_count <= rd_count + 32'd1;
            end
            if (issue_wr) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_sram_shift_responder.sv
// Bench for sram_shift_responder: timestamp-based transaction model plus a small SRAM model,
// directed scenarios with literal expectations, then a randomized request/reset phase.
module tb_sram_shift_responder;

    localparam int AW = 19;
    localparam int DW = 72;
    localparam int L  = 2;
    localparam int TA = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_ack, rd_vld, wr_ack;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_addr;
    logic          sram_we, sram_cs;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          proto_err;
    logic [31:0]   rd_count, wr_count;

    sram_shift_responder #(
        .SRAM_ADDR_WIDTH(AW),
        .SRAM_DATA_WIDTH(DW),
        .SRAM_RD_LATENCY(L),
        .WR_TURNAROUND  (TA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_cs   (sram_cs),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .proto_err (proto_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vld_seen = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        logic [63:0] m;
        m = 64'(a) * 64'h9E3779B97F4A7C15;
        return {8'hAA, m};
    endfunction

    // SRAM model: data for a read command appears L-1 cycles after the command is seen.
    logic          hv[L];
    logic [AW-1:0] ha[L];
    always @(negedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            hv[i] = hv[i-1];
            ha[i] = ha[i-1];
        end
        hv[0] = (sram_cs === 1'b1) && (sram_we === 1'b0);
        ha[0] = sram_addr;
        sram_rdata = hv[L-1] ? data_of(ha[L-1]) : DW'({$urandom, $urandom, $urandom});
    end

    // Reference model: requests are held per type, each edge at most one op issues,
    // a write following a read is deferred to a fixed future edge, and reads
    // return their data at issue edge + L.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_ret_t;

    rd_ret_t       m_rdq[$];
    bit            model_live = 0;
    bit            m_rd_pend, m_wr_pend, m_last_rd, m_wsched;
    int            m_wsched_edge;
    int            m_iss;
    logic [AW-1:0] m_rd_addr, m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            m_perr;
    logic [31:0]   m_rc, m_wc;
    logic          e_cs, e_we, e_rack, e_wack, e_vld;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    always @(posedge clk) begin
        model_live = 1;
        cyc++;
        e_vld = 0;
        if (reset) begin
            m_rd_pend = 0; m_wr_pend = 0; m_last_rd = 0; m_wsched = 0; m_perr = 0;
            m_rc = 0; m_wc = 0;
            m_rdq.delete();
            e_cs = 0; e_we = 0; e_rack = 0; e_wack = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
        end else begin
            m_iss = 0;
            if (m_wsched) begin
                if (cyc == m_wsched_edge) begin
                    m_iss = 2;
                    m_wsched = 0;
                end
            end else if (m_rd_pend && (!m_wr_pend || !m_last_rd)) begin
                m_iss = 1;
            end else if (m_wr_pend) begin
                if (m_last_rd && TA > 0) begin
                    m_wsched = 1;
                    m_wsched_edge = cyc + TA;
                end else begin
                    m_iss = 2;
                end
            end

            e_cs = (m_iss != 0);
            e_we = (m_iss == 2);
            e_rack = (m_iss == 1);
            e_wack = (m_iss == 2);
            if (m_iss == 1) begin
                e_addr = m_rd_addr;
                m_rd_pend = 0;
                m_last_rd = 1;
                m_rc++;
                m_rdq.push_back('{due: cyc + L, data: data_of(m_rd_addr)});
            end else if (m_iss == 2) begin
                e_addr = m_wr_addr;
                e_wdata = m_wr_data;
                m_wr_pend = 0;
                m_last_rd = 0;
                m_wc++;
            end

            if (rd_req) begin
                if (m_rd_pend) m_perr = 1;
                else begin
                    m_rd_pend = 1;
                    m_rd_addr = rd_addr;
                end
            end
            if (wr_req) begin
                if (m_wr_pend) m_perr = 1;
                else begin
                    m_wr_pend = 1;
                    m_wr_addr = wr_addr;
                    m_wr_data = wr_data;
                end
            end

            if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
                e_vld = 1;
                e_rdata = m_rdq[0].data;
                void'(m_rdq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("sram_cs", sram_cs, e_cs);
            check("rd_ack", rd_ack, e_rack);
            check("wr_ack", wr_ack, e_wack);
            check("rd_vld", rd_vld, e_vld);
            check("proto_err", proto_err, m_perr);
            if (e_cs) begin
                check("sram_we", sram_we, e_we);
                check("sram_addr", sram_addr, e_addr);
            end
            if (e_cs && e_we) check("sram_wdata", sram_wdata, e_wdata);
            if (e_vld) check("rd_data", rd_data, e_rdata);
`ifdef SHIFT_RESP_STATS_EN
            check("rd_count", rd_count, m_rc);
            check("wr_count", wr_count, m_wc);
`else
            check("rd_count", rd_count, 0);
            check("wr_count", wr_count, 0);
`endif
            if (rd_vld === 1'b1) vld_seen++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
        repeat (3) @(negedge clk);
        check("reset_sram_cs", sram_cs, 0);
        check("reset_rd_vld", rd_vld, 0);
        check("reset_sram_addr", sram_addr, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_proto_err", proto_err, 0);

        // Single write right after reset: no turnaround.
        reset = 1'b0;
        @(negedge clk); wr_req = 1; wr_addr = 19'h7FFFE; wr_data = 72'h1234;
        @(negedge clk); wr_req = 0;
        @(negedge clk);
        check("wr1_cs", sram_cs, 1);
        check("wr1_we", sram_we, 1);
        check("wr1_addr", sram_addr, 19'h7FFFE);
        check("wr1_wdata", sram_wdata, 72'h1234);
        check("wr1_ack", wr_ack, 1);

        // Single read, latency 2.
        do_reset();
        @(negedge clk); rd_req = 1; rd_addr = 19'h00010;
        @(negedge clk); rd_req = 0;
        @(negedge clk);
        check("rd1_ack", rd_ack, 1);
        check("rd1_cs", sram_cs, 1);
        check("rd1_we", sram_we, 0);
        check("rd1_addr", sram_addr, 19'h00010);
        @(negedge clk);
        check("rd1_vld_early", rd_vld, 0);
        @(negedge clk);
        check("rd1_vld", rd_vld, 1);
        check("rd1_data", rd_data, 72'hAA_E377_9B97_F4A7_C150);

        // Simultaneous read and write: read, turnaround, write.
        do_reset();
        @(negedge clk); rd_req = 1; rd_addr = 19'h55; wr_req = 1; wr_addr = 19'h66; wr_data = 72'hBEEF;
        @(negedge clk); rd_req = 0; wr_req = 0;
        @(negedge clk);
        check("sim_rd_ack", rd_ack, 1);
        check("sim_wr_ack_e1", wr_ack, 0);
        check("sim_we_e1", sram_we, 0);
        @(negedge clk);
        check("sim_cs_turn", sram_cs, 0);
        @(negedge clk);
        check("sim_wr_ack", wr_ack, 1);
        check("sim_we_e3", sram_we, 1);
        check("sim_addr_e3", sram_addr, 19'h66);

        // Five reads back to back, request re-armed on the issue edge.
        do_reset();
        @(negedge clk);
        vld_seen = 0;
        for (int i = 0; i < 5; i++) begin
            rd_req = 1; rd_addr = AW'(i);
            @(negedge clk);
        end
        rd_req = 0;
        repeat (6) @(negedge clk);
        check("b2b_vld_count", vld_seen, 5);
        check("b2b_proto_err", proto_err, 0);

        // Duplicate read while one is held behind a turnaround.
        do_reset();
        @(negedge clk); rd_req = 1; rd_addr = 19'h100; wr_req = 1; wr_addr = 19'h200; wr_data = 72'h77;
        @(negedge clk); wr_req = 0; rd_addr = 19'h101;
        @(negedge clk); rd_addr = 19'h102;
        @(negedge clk); rd_req = 0;
        check("perr_set", proto_err, 1);
        check("perr_turn_cs", sram_cs, 0);
        @(negedge clk);
        check("perr_wr_addr", sram_addr, 19'h200);
        @(negedge clk);
        check("perr_held_rd_addr", sram_addr, 19'h101);
        @(negedge clk);
        check("perr_dropped_rd", sram_cs, 0);
        repeat (5) @(negedge clk);
        check("perr_sticky", proto_err, 1);
        do_reset();
        check("perr_cleared", proto_err, 0);

        // Reset one cycle after a read command kills the in-flight read.
        @(negedge clk); rd_req = 1; rd_addr = 19'h33;
        @(negedge clk); rd_req = 0;
        @(negedge clk); reset = 1;
        vld_seen = 0;
        @(negedge clk);
        check("inflight_cs", sram_cs, 0);
        check("inflight_ack", rd_ack, 0);
        check("inflight_addr", sram_addr, 0);
        @(negedge clk); reset = 0;
        repeat (4) @(negedge clk);
        check("inflight_no_vld", vld_seen, 0);

        // Three reads and two writes for the counters.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rd_req = 1; rd_addr = AW'(i + 8);
            @(negedge clk); rd_req = 0;
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); wr_req = 1; wr_addr = AW'(i + 20); wr_data = DW'(i);
            @(negedge clk); wr_req = 0;
            repeat (4) @(negedge clk);
        end
`ifdef SHIFT_RESP_STATS_EN
        check("cnt_rd", rd_count, 3);
        check("cnt_wr", wr_count, 2);
`else
        check("cnt_rd_tied", rd_count, 0);
        check("cnt_wr_tied", wr_count, 0);
`endif

        // Randomized traffic with occasional reset.
        repeat (3000) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 299) == 0);
            rd_req  = ($urandom_range(0, 99) < 45);
            wr_req  = ($urandom_range(0, 99) < 35);
            rd_addr = AW'($urandom);
            wr_addr = AW'($urandom);
            wr_data = DW'({$urandom, $urandom, $urandom});
        end
        @(negedge clk);
        reset = 0; rd_req = 0; wr_req = 0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_shift_responder.md
# sram_shift_responder

Responder end of the shift-engine SRAM request interface: accepts one-cycle read and write request pulses from the shift-marking initiator, arbitrates them onto a single synchronous SRAM port, returns per-request acks, and delivers read data with a valid strobe after a fixed pipeline latency. Sits between the shift engine and the SRAM controller pins/model, one instance per shift engine.

## Interface
Parameters:
- SRAM_ADDR_WIDTH, 19, address width
- SRAM_DATA_WIDTH, 72, data word width
- SRAM_RD_LATENCY, 2, edges from SRAM command to read data sampled (1..4)
- WR_TURNAROUND, 1, idle cycles inserted when a write follows a read (0..3)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request pulse (one cycle)
- rd_addr  in  SRAM_ADDR_WIDTH  read address, sampled with rd_req
- rd_ack  out  1  read accepted/issued, one-cycle pulse
- rd_data  out  SRAM_DATA_WIDTH  read data
- rd_vld  out  1  rd_data valid, one-cycle pulse per read
- wr_req  in  1  write request pulse (one cycle)
- wr_addr  in  SRAM_ADDR_WIDTH  write address, sampled with wr_req
- wr_data  in  SRAM_DATA_WIDTH  write data, sampled with wr_req
- wr_ack  out  1  write issued, one-cycle pulse
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM address
- sram_we  out  1  SRAM write enable (1 = write)
- sram_cs  out  1  SRAM command valid
- sram_wdata  out  SRAM_DATA_WIDTH  SRAM write data
- sram_rdata  in  SRAM_DATA_WIDTH  SRAM read data
- proto_err  out  1  sticky: request received while same-type request pending
- rd_count, wr_count  out  32 each  issued-op counters (see Configuration)

## Operation
- Capture: rd_req at edge N loads rd_pend=1, rd_addr_q; wr_req loads wr_pend=1, wr_addr_q, wr_data_q. Both may arrive the same edge.
- Request while its pend bit already set: ignored (held request kept), proto_err set until reset.
- Arbiter FSM states: IDLE, ISSUE_RD, ISSUE_WR, TURN.
  - IDLE/ISSUE_*: choose next op from pend bits; both pending -> the type not issued last (round-robin; after reset read first).
  - Write chosen and last issued op was read and WR_TURNAROUND>0 -> TURN, count WR_TURNAROUND cycles with sram_cs=0, then ISSUE_WR.
  - Nothing pending -> IDLE.
- Issue: registers sram_cs=1, sram_we, sram_addr, sram_wdata (write only; holds last value otherwise), pulses matching ack, clears pend bit. Pend may be re-set by a new req the same edge it clears (no proto_err).
- Read pipeline: SRAM_RD_LATENCY-deep valid shift register; at command edge C+SRAM_RD_LATENCY, rd_data <= sram_rdata, rd_vld=1. Back-to-back reads produce back-to-back vld in issue order.
- Counters wrap at 2^32.

## Timing
- Reset values: all outputs 0; pend bits, pipeline, FSM (IDLE), last-op (write), counters cleared. In-flight reads at reset never produce rd_vld.
- Minimum req->ack: req sampled edge N, command + ack registered at edge N+1 (ack high cycle after N+1).
- Read: rd_vld at edge N+1+SRAM_RD_LATENCY minimum.
- Write after read: extra WR_TURNAROUND cycles between read command and write command.
- Throughput: one SRAM command per cycle excluding turnaround; max one outstanding request per type, so at most 2 pending.
- sram_cs is high for exactly one cycle per ack.

## Configuration
- SHIFT_RESP_STATS_EN defined: rd_count/wr_count increment on each rd_ack/wr_ack.
- Undefined: counter logic omitted, rd_count/wr_count tied to 0; proto_err and all other behaviour identical.

## Test plan
- Single read, addr 0x00010, L=2, SRAM model returns 0xAA..: rd_req edge 0 -> rd_ack/sram_cs edge 1, rd_vld with data at edge 3.
- Single write addr 0x7FFFE data 0x1234: wr_req edge 0 -> sram_cs=1, sram_we=1, addr/data match at edge 1, wr_ack same cycle.
- Simultaneous rd_req+wr_req after reset, WR_TURNAROUND=1: read issued edge 1, idle edge 2, write edge 3; acks in that order.
- Five back-to-back read pulses (each after ack): rd_vld five times in issue order, addresses 0..4 data matches model.
- Second rd_req while rd_pend set: only first read issued, proto_err=1 and stays until reset.
- Reset asserted one cycle after read command: no rd_vld, all outputs 0 next cycle; with SHIFT_RESP_STATS_EN, 3 reads + 2 writes -> rd_count=3, wr_count=2.
